// File: rtl/config_pkg.sv
// rtl/config_pkg.sv - config stream constants, header field layout and decoder states
package config_pkg;

    localparam logic [31:0] SYNC_WORD       = 32'hFAB0_FAB1;
    localparam int          DESYNC_FLAG_POS = 20;
    localparam int          ROW_MSB         = 31;
    localparam int          ROW_LSB         = 24;
    localparam int          LEN_MSB         = 15;
    localparam int          LEN_LSB         = 0;

    typedef enum logic [1:0] {
        IDLE,
        HEADER,
        DATA,
        ERROR
    } cfg_state_t;

    function automatic logic [7:0] hdr_row(input logic [31:0] word);
        return word[ROW_MSB:ROW_LSB];
    endfunction

    function automatic logic [15:0] hdr_len(input logic [31:0] word);
        return word[LEN_MSB:LEN_LSB];
    endfunction

endpackage

// File: rtl/config_header_check.sv
// rtl/config_header_check.sv - combinational classification of a candidate header word
module config_header_check
    import config_pkg::*;
#(
    parameter int NUM_ROWS  = 16,
    parameter int MAX_WORDS = 20
) (
    input  logic [31:0] word,
    output logic        is_sync,
    output logic        is_desync,
    output logic        hdr_valid,
    output logic        len_zero,
    output logic [7:0]  row,
    output logic [15:0] len
);

    assign row       = hdr_row(word);
    assign len       = hdr_len(word);
    assign is_sync   = (word == SYNC_WORD);
    assign is_desync = word[DESYNC_FLAG_POS];
    assign hdr_valid = ({24'd0, row} < 32'(NUM_ROWS)) && ({16'd0, len} <= 32'(MAX_WORDS));
    assign len_zero  = (len == 16'd0);

endmodule

// File: rtl/config_frame_decoder.sv
// rtl/config_frame_decoder.sv - decodes the config word stream into per-row frame writes
module config_frame_decoder
    import config_pkg::*;
#(
    parameter int NUM_ROWS  = 16,
    parameter int MAX_WORDS = 20
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic                word_strobe_i,
    input  logic [31:0]         word_data_i,
    output logic [31:0]         frame_data_o,
    output logic [NUM_ROWS-1:0] row_strobe_o,
    output logic [4:0]          word_index_o,
    output logic                busy_o,
    output logic                config_done_o,
    output logic                error_o
);

    localparam logic [NUM_ROWS-1:0] ROW_ONE = {{(NUM_ROWS-1){1'b0}}, 1'b1};

    logic [1:0]  rst_pipe;
    logic        rst;
    cfg_state_t  state;
    logic [7:0]  row_q;
    logic [4:0]  cnt;
    logic [15:0] remaining;

    logic        is_sync;
    logic        is_desync;
    logic        hdr_valid;
    logic        len_zero;
    logic [7:0]  hdr_row_w;
    logic [15:0] hdr_len_w;

    // Assert immediately, release only on a clock edge.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            rst_pipe <= 2'b11;
        end else begin
            rst_pipe <= {rst_pipe[0], 1'b0};
        end
    end

    assign rst = rst_pipe[1];

    config_header_check #(
        .NUM_ROWS  (NUM_ROWS),
        .MAX_WORDS (MAX_WORDS)
    ) u_header_check (
        .word      (word_data_i),
        .is_sync   (is_sync),
        .is_desync (is_desync),
        .hdr_valid (hdr_valid),
        .len_zero  (len_zero),
        .row       (hdr_row_w),
        .len       (hdr_len_w)
    );

    always_ff @(posedge clk_i or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            row_q         <= 8'd0;
            cnt           <= 5'd0;
            remaining     <= 16'd0;
            frame_data_o  <= 32'd0;
            row_strobe_o  <= '0;
            word_index_o  <= 5'd0;
            busy_o        <= 1'b0;
            config_done_o <= 1'b0;
            error_o       <= 1'b0;
        end else begin
            row_strobe_o  <= '0;
            config_done_o <= 1'b0;
            if (word_strobe_i) begin
                case (state)
                    IDLE: begin
                        if (is_sync) begin
                            state  <= HEADER;
                            busy_o <= 1'b1;
                        end
                    end
                    HEADER: begin
                        // The sync word itself has bit 20 set, so resync must win over desync.
                        if (is_sync) begin
                            state <= HEADER;
                        end else if (is_desync) begin
                            config_done_o <= 1'b1;
                            busy_o        <= 1'b0;
                            state         <= IDLE;
                        end else if (!hdr_valid) begin
                            error_o <= 1'b1;
                            busy_o  <= 1'b0;
                            state   <= ERROR;
                        end else if (!len_zero) begin
                            row_q     <= hdr_row_w;
                            cnt       <= 5'd0;
                            remaining <= hdr_len_w;
                            state     <= DATA;
                        end
                    end
                    DATA: begin
                        frame_data_o <= word_data_i;
                        row_strobe_o <= ROW_ONE << row_q;
                        word_index_o <= cnt;
                        cnt          <= cnt + 5'd1;
                        remaining    <= remaining - 16'd1;
                        if (remaining == 16'd1) begin
                            state <= HEADER;
                        end
                    end
                    ERROR: begin
                        if (is_sync) begin
                            error_o <= 1'b0;
                            busy_o  <= 1'b1;
                            state   <= HEADER;
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_config_frame_decoder.sv
// tb/tb_config_frame_decoder.sv - self-checking bench for config_frame_decoder
module tb_config_frame_decoder;

    localparam int          NUM_ROWS  = 16;
    localparam int          MAX_WORDS = 20;
    localparam logic [31:0] SYNC      = 32'hFAB0_FAB1;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        strobe = 1'b0;
    logic [31:0] data = 32'd0;
    logic [31:0] frame_data;
    logic [15:0] row_strobe;
    logic [4:0]  word_index;
    logic        busy;
    logic        config_done;
    logic        error;

    int checks = 0;
    int fails  = 0;

    config_frame_decoder #(
        .NUM_ROWS  (NUM_ROWS),
        .MAX_WORDS (MAX_WORDS)
    ) dut (
        .clk_i         (clk),
        .reset_i       (reset),
        .word_strobe_i (strobe),
        .word_data_i   (data),
        .frame_data_o  (frame_data),
        .row_strobe_o  (row_strobe),
        .word_index_o  (word_index),
        .busy_o        (busy),
        .config_done_o (config_done),
        .error_o       (error)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        strobe;
        logic [31:0] word;
        logic [15:0] rs;
        logic        done;
        logic [31:0] frame;
        logic [4:0]  idx;
        logic        busy;
        logic        err;
    } item_t;

    item_t q[$];

    // Session-level model: 0 = waiting for sync, 1 = expecting headers, 2 = error lockout.
    int          m_mode  = 0;
    logic [31:0] m_frame = 32'd0;
    logic [4:0]  m_index = 5'd0;
    logic        m_busy  = 1'b0;
    logic        m_err   = 1'b0;

    function automatic logic [31:0] mk_hdr(input int row, input int len);
        logic [2:0] hi = 3'($urandom);
        logic [3:0] lo = 4'($urandom);
        return {8'(row), hi, 1'b0, lo, 16'(len)};
    endfunction

    function automatic logic [31:0] rand_not_sync();
        logic [31:0] w;
        do w = $urandom; while (w == SYNC);
        return w;
    endfunction

    task automatic push(input logic s, input logic [31:0] w, input logic [15:0] rs, input logic done);
        item_t it;
        it.strobe = s;
        it.word   = w;
        it.rs     = rs;
        it.done   = done;
        it.frame  = m_frame;
        it.idx    = m_index;
        it.busy   = m_busy;
        it.err    = m_err;
        q.push_back(it);
    endtask

    task automatic add_gap(input int n);
        repeat (n) push(1'b0, $urandom, 16'd0, 1'b0);
    endtask

    task automatic add_sync();
        if (m_mode != 1) begin
            m_busy = 1'b1;
            m_err  = 1'b0;
            m_mode = 1;
        end
        push(1'b1, SYNC, 16'd0, 1'b0);
    endtask

    task automatic add_frame(input int row, input logic [31:0] p[$], input bit gaps);
        push(1'b1, mk_hdr(row, p.size()), 16'd0, 1'b0);
        for (int i = 0; i < p.size(); i++) begin
            if (gaps && ($urandom_range(0, 3) == 0)) add_gap($urandom_range(1, 2));
            m_frame = p[i];
            m_index = 5'(i);
            push(1'b1, p[i], 16'd1 << row, 1'b0);
        end
    endtask

    task automatic add_desync(input logic [31:0] w);
        m_busy = 1'b0;
        m_mode = 0;
        push(1'b1, w, 16'd0, 1'b1);
    endtask

    task automatic add_bad(input logic [31:0] w);
        m_busy = 1'b0;
        m_err  = 1'b1;
        m_mode = 2;
        push(1'b1, w, 16'd0, 1'b0);
    endtask

    task automatic drive(input item_t it);
        @(negedge clk);
        strobe = it.strobe;
        data   = it.word;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if ({row_strobe, config_done, frame_data, word_index, busy, error} !== 56'd0) begin
            fails++;
            $display("FAIL reset_held: got rs=%h done=%b data=%h idx=%0d busy=%b err=%b want all zero",
                     row_strobe, config_done, frame_data, word_index, busy, error);
        end
        reset = 1'b0;
        repeat (4) @(negedge clk);
        checks++;
        if ({row_strobe, config_done, frame_data, word_index, busy, error} !== 56'd0) begin
            fails++;
            $display("FAIL reset_released: got rs=%h done=%b data=%h idx=%0d busy=%b err=%b want all zero",
                     row_strobe, config_done, frame_data, word_index, busy, error);
        end
    endtask

    task automatic test_basic_and_desync();
        logic [31:0] p[$];
        push(1'b1, 32'h1234_0000, 16'd0, 1'b0);
        add_sync();
        p = '{32'hA5A5_0001, 32'h5A5A_0002};
        add_frame(3, p, 1'b0);
        add_gap(2);
        add_desync(32'h0010_0000);
        add_gap(2);
        foreach (q[i]) begin
            drive(q[i]);
            checks++;
            if ({row_strobe, config_done, frame_data, word_index, busy, error} !==
                {q[i].rs, q[i].done, q[i].frame, q[i].idx, q[i].busy, q[i].err}) begin
                fails++;
                $display("FAIL basic_desync[%0d]: got rs=%h done=%b data=%h idx=%0d busy=%b err=%b want rs=%h done=%b data=%h idx=%0d busy=%b err=%b",
                         i, row_strobe, config_done, frame_data, word_index, busy, error,
                         q[i].rs, q[i].done, q[i].frame, q[i].idx, q[i].busy, q[i].err);
            end
        end
        q.delete();
    endtask

    task automatic test_error_recovery();
        logic [31:0] p[$];
        add_sync();
        add_bad(mk_hdr(16, 1));
        push(1'b1, mk_hdr(2, 1), 16'd0, 1'b0);
        push(1'b1, 32'hDEAD_BEEF, 16'd0, 1'b0);
        push(1'b1, 32'h0010_0000, 16'd0, 1'b0);
        add_gap(1);
        add_sync();
        p = '{32'hC0DE_0005};
        add_frame(5, p, 1'b0);
        add_desync(32'h0010_0000);
        add_gap(1);
        foreach (q[i]) begin
            drive(q[i]);
            checks++;
            if ({row_strobe, config_done, frame_data, word_index, busy, error} !==
                {q[i].rs, q[i].done, q[i].frame, q[i].idx, q[i].busy, q[i].err}) begin
                fails++;
                $display("FAIL error_recovery[%0d]: got rs=%h done=%b data=%h idx=%0d busy=%b err=%b want rs=%h done=%b data=%h idx=%0d busy=%b err=%b",
                         i, row_strobe, config_done, frame_data, word_index, busy, error,
                         q[i].rs, q[i].done, q[i].frame, q[i].idx, q[i].busy, q[i].err);
            end
        end
        q.delete();
    endtask

    task automatic test_sync_payload_and_empty();
        logic [31:0] p[$];
        add_sync();
        p = '{SYNC, 32'h0010_0000, 32'h0123_4567};
        add_frame(9, p, 1'b0);
        add_sync();
        push(1'b1, mk_hdr(7, 0), 16'd0, 1'b0);
        p = '{32'h1234_5678};
        add_frame(0, p, 1'b0);
        add_gap(1);
        add_desync(32'h0010_0000);
        add_gap(1);
        foreach (q[i]) begin
            drive(q[i]);
            checks++;
            if ({row_strobe, config_done, frame_data, word_index, busy, error} !==
                {q[i].rs, q[i].done, q[i].frame, q[i].idx, q[i].busy, q[i].err}) begin
                fails++;
                $display("FAIL sync_payload_empty[%0d]: got rs=%h done=%b data=%h idx=%0d busy=%b err=%b want rs=%h done=%b data=%h idx=%0d busy=%b err=%b",
                         i, row_strobe, config_done, frame_data, word_index, busy, error,
                         q[i].rs, q[i].done, q[i].frame, q[i].idx, q[i].busy, q[i].err);
            end
        end
        q.delete();
    endtask

    task automatic test_length_bounds();
        logic [31:0] p[$];
        add_sync();
        p = {};
        for (int i = 0; i < MAX_WORDS; i++) p.push_back($urandom);
        add_frame(15, p, 1'b0);
        add_bad(mk_hdr(0, MAX_WORDS + 1));
        add_sync();
        add_bad(mk_hdr(255, 3));
        add_sync();
        add_desync({8'hFF, 3'b000, 1'b1, 20'hFFFFF});
        add_gap(1);
        foreach (q[i]) begin
            drive(q[i]);
            checks++;
            if ({row_strobe, config_done, frame_data, word_index, busy, error} !==
                {q[i].rs, q[i].done, q[i].frame, q[i].idx, q[i].busy, q[i].err}) begin
                fails++;
                $display("FAIL length_bounds[%0d]: got rs=%h done=%b data=%h idx=%0d busy=%b err=%b want rs=%h done=%b data=%h idx=%0d busy=%b err=%b",
                         i, row_strobe, config_done, frame_data, word_index, busy, error,
                         q[i].rs, q[i].done, q[i].frame, q[i].idx, q[i].busy, q[i].err);
            end
        end
        q.delete();
    endtask

    task automatic test_reset_mid_frame();
        logic [31:0] p[$];
        add_sync();
        push(1'b1, mk_hdr(4, 3), 16'd0, 1'b0);
        m_frame = 32'h7777_0000;
        m_index = 5'd0;
        push(1'b1, 32'h7777_0000, 16'd1 << 4, 1'b0);
        foreach (q[i]) begin
            drive(q[i]);
            checks++;
            if ({row_strobe, config_done, frame_data, word_index, busy, error} !==
                {q[i].rs, q[i].done, q[i].frame, q[i].idx, q[i].busy, q[i].err}) begin
                fails++;
                $display("FAIL reset_mid_pre[%0d]: got rs=%h done=%b data=%h idx=%0d busy=%b err=%b want rs=%h done=%b data=%h idx=%0d busy=%b err=%b",
                         i, row_strobe, config_done, frame_data, word_index, busy, error,
                         q[i].rs, q[i].done, q[i].frame, q[i].idx, q[i].busy, q[i].err);
            end
        end
        q.delete();
        #2;
        reset  = 1'b1;
        strobe = 1'b0;
        #1;
        checks++;
        if ({row_strobe, config_done, frame_data, word_index, busy, error} !== 56'd0) begin
            fails++;
            $display("FAIL reset_mid_async: got rs=%h done=%b data=%h idx=%0d busy=%b err=%b want all zero",
                     row_strobe, config_done, frame_data, word_index, busy, error);
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        m_mode  = 0;
        m_frame = 32'd0;
        m_index = 5'd0;
        m_busy  = 1'b0;
        m_err   = 1'b0;
        push(1'b1, 32'h8888_0001, 16'd0, 1'b0);
        push(1'b1, mk_hdr(4, 1), 16'd0, 1'b0);
        add_gap(2);
        foreach (q[i]) begin
            drive(q[i]);
            checks++;
            if ({row_strobe, config_done, frame_data, word_index, busy, error} !==
                {q[i].rs, q[i].done, q[i].frame, q[i].idx, q[i].busy, q[i].err}) begin
                fails++;
                $display("FAIL reset_mid_post[%0d]: got rs=%h done=%b data=%h idx=%0d busy=%b err=%b want rs=%h done=%b data=%h idx=%0d busy=%b err=%b",
                         i, row_strobe, config_done, frame_data, word_index, busy, error,
                         q[i].rs, q[i].done, q[i].frame, q[i].idx, q[i].busy, q[i].err);
            end
        end
        q.delete();
    endtask

    task automatic test_random_back_to_back();
        logic [31:0] p[$];
        logic [31:0] w;
        int          pick;
        int          len;
        for (int seg = 0; seg < 200; seg++) begin
            pick = $urandom_range(0, 99);
            if (m_mode == 1) begin
                if (pick < 50) begin
                    len = ($urandom_range(0, 3) == 0) ? MAX_WORDS : $urandom_range(1, MAX_WORDS);
                    p = {};
                    for (int i = 0; i < len; i++)
                        p.push_back(($urandom_range(0, 7) == 0) ? SYNC : $urandom);
                    add_frame($urandom_range(0, NUM_ROWS - 1), p, $urandom_range(0, 1) == 1);
                end else if (pick < 60) begin
                    push(1'b1, mk_hdr($urandom_range(0, NUM_ROWS - 1), 0), 16'd0, 1'b0);
                end else if (pick < 70) begin
                    add_sync();
                end else if (pick < 80) begin
                    w = rand_not_sync();
                    w[20] = 1'b1;
                    if (w == SYNC) w[0] = 1'b0;
                    add_desync(w);
                end else if (pick < 90) begin
                    add_bad(mk_hdr($urandom_range(NUM_ROWS, 255), $urandom_range(0, 65535)));
                end else begin
                    add_bad(mk_hdr($urandom_range(0, NUM_ROWS - 1), $urandom_range(MAX_WORDS + 1, 65535)));
                end
            end else if (pick < 40) begin
                push(1'b1, rand_not_sync(), 16'd0, 1'b0);
            end else begin
                add_sync();
            end
            if ($urandom_range(0, 3) == 0) add_gap($urandom_range(1, 3));
        end
        add_gap(1);
        foreach (q[i]) begin
            drive(q[i]);
            checks++;
            if ({row_strobe, config_done, frame_data, word_index, busy, error} !==
                {q[i].rs, q[i].done, q[i].frame, q[i].idx, q[i].busy, q[i].err}) begin
                fails++;
                $display("FAIL random[%0d]: in=%h got rs=%h done=%b data=%h idx=%0d busy=%b err=%b want rs=%h done=%b data=%h idx=%0d busy=%b err=%b",
                         i, q[i].word, row_strobe, config_done, frame_data, word_index, busy, error,
                         q[i].rs, q[i].done, q[i].frame, q[i].idx, q[i].busy, q[i].err);
            end
        end
        q.delete();
    endtask

    initial begin
        test_reset();
        test_basic_and_desync();
        test_error_recovery();
        test_sync_payload_and_empty();
        test_length_bounds();
        test_reset_mid_frame();
        test_random_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
